// File: rtl/packed_lane_sequencer.sv
// Serialises a packed word of LANES elements onto a W-bit element stream,
// emitting only the lanes selected by a per-word mask, lowest lane first.
module packed_lane_sequencer #(
    parameter int LANES = 4,
    parameter int W     = 8,
    localparam int IDX_W = $clog2(LANES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*W-1:0]   in_data,
    input  logic [LANES-1:0]     in_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic [IDX_W-1:0]     out_lane,
    output logic                 out_last,
    output logic                 busy,
    output logic [7:0]           drop_count
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // A producer holding valid must keep its payload stable until ready;
    // here out_* is a pure function of held state, so it cannot move while
    // out_ready is low. in_ready depends only on state, never on in_valid.

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [LANES-1:0] MASK_ONE = {{(LANES-1){1'b0}}, 1'b1};

    state_t                state;
    state_t                state_next;
    logic [LANES*W-1:0]    held_data;
    logic [LANES-1:0]      held_mask;
    logic [IDX_W-1:0]      lane_sel;
    logic                  single_left;
    logic                  accept;
    logic                  advance;

    // Lowest set bit of the remaining mask; the loop runs high-to-low so the
    // last assignment wins with the smallest index.
    always_comb begin
        lane_sel = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (held_mask[i]) begin
                lane_sel = IDX_W'(i);
            end
        end
    end

    assign single_left = (held_mask != '0) &&
                         ((held_mask & (held_mask - MASK_ONE)) == '0);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        out_data   = '0;
        out_lane   = '0;
        out_last   = 1'b0;
        accept     = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && (in_mask != '0)) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_lane  = lane_sel;
                out_data  = held_data[int'(lane_sel) * W +: W];
                out_last  = single_left;
                advance   = out_ready;
                if (out_ready && single_left) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The word is captured only in IDLE; during SEND only mask bits retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_data <= '0;
            held_mask <= '0;
        end else if (accept) begin
            held_data <= in_data;
            held_mask <= in_mask;
        end else if (advance) begin
            held_mask <= held_mask & (held_mask - MASK_ONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (accept && (in_mask == '0) && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

endmodule
